load_store_unit: RTL

- Sits directly downstream of the single-cycle core's data port (MemRead, MemWrite, dAddress, dWriteData, funct3).
- Turns each core load/store into one handshaked word transaction on the data-memory bus.
- Generates byte enables and store-data lane replication; extracts load data with sign or zero extension.
- Stalls the core (PC hold) until the access completes.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_load_align.sv | 22 ++
 rtl/load_store_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM encoding, byte-enable patterns and store-enable helper for the load/store unit.
package lsu_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] BE_B   = 4'b0001;
    localparam logic [3:0] BE_HLO = 4'b0011;
    localparam logic [3:0] BE_HHI = 4'b1100;
    localparam logic [3:0] BE_W   = 4'b1111;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        return f3[1:0] == F3_LB[1:0] ? BE_B << a :
               f3[1:0] == F3_LH[1:0] ? (a[1] ? BE_HHI : BE_HLO) : BE_W;
    endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/halfword lane of a bus word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  f3_i,
    output logic [31:0] value_o
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = word_i[8*off_i +: 8];
    assign h = off_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        value_o = f3_i == F3_LB  ? {{24{b[7]}}, b}  :
                  f3_i == F3_LBU ? {24'b0, b}       :
                  f3_i == F3_LH  ? {{16{h[15]}}, h} :
                  f3_i == F3_LHU ? {16'b0, h}       : word_i;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one handshaked word bus transaction per core load/store, stalling the core until done; LSU_TIMEOUT_EN adds an abort timer.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);
    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q, wdata_q, rdata_q, ld_val;
    logic [3:0]  be_q;
    logic        access, misalign, illegal, start, busy, tmo;

    assign access   = mem_read ^ mem_write;
    assign misalign = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign illegal  = funct3 == 3'b011 || funct3[2:1] == 2'b11;
    assign fault    = (mem_read & mem_write) | ((mem_read | mem_write) & (misalign | illegal));
    assign start    = state_q == S_IDLE && access && !fault;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_REQ : S_IDLE;
            S_REQ:   state_d = tmo ? S_DONE : bus_gnt ? (we_q ? S_DONE : S_WAIT) : S_REQ;
            S_WAIT:  state_d = (tmo || bus_rvalid) ? S_DONE : S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    // stall is gated by reset so the core is released the moment reset asserts
    always_comb begin
        busy    = state_q == S_REQ || state_q == S_WAIT;
        bus_req = state_q == S_REQ;
        stall   = rst && (start || busy);
    end

    lsu_load_align u_align (
        .word_i  (bus_rdata),
        .off_i   (off_q),
        .f3_i    (f3_q),
        .value_o (ld_val)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b0;
            off_q   <= 2'b0;
            addr_q  <= '0;
            be_q    <= 4'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (start) begin
                we_q    <= mem_write;
                f3_q    <= funct3;
                off_q   <= addr[1:0];
                addr_q  <= {addr[31:2], 2'b00};
                be_q    <= mem_write ? store_be(funct3, addr[1:0]) : BE_W;
                wdata_q <= funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                           funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
            end
            if (state_q == S_WAIT && bus_rvalid) rdata_q <= ld_val;
            else if (tmo && !we_q)               rdata_q <= '0;
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       cnt_q <= '0;
        else if (start) cnt_q <= '0;
        else if (busy)  cnt_q <= cnt_q + CW'(1);
    end

    assign tmo     = busy && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign bus_err = tmo;
`else
    assign tmo     = 1'b0;
    assign bus_err = tmo & (TIMEOUT_CYCLES > 0);
`endif

    assign rdata     = rdata_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
endmodule
